msix_vec_gen: RTL and testbench
===============================

# msix_vec_gen

MSI-X message generator sitting directly upstream of the host memory interface. It holds a per-vector MSI-X table (address, data, mask) and a pending-bit array. It arbitrates pending, unmasked vectors round-robin and emits one DW memory write per interrupt (address = vector address, data = vector data) toward the host. The host side detects the MSI-X write by address match.

## Interface
- NUM_VEC, 8: number of MSI-X vectors, 2..32
- IDX_W, $clog2(NUM_VEC): vector index width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- msix_en  in  1  MSI-X enable (control register)
- func_mask  in  1  function mask; blocks all issuance while 1
- tbl_wr_en  in  1  table entry write strobe
- tbl_wr_idx  in  IDX_W  entry index
- tbl_wr_addr  in  64  message address
- tbl_wr_data  in  32  message data
- tbl_wr_mask  in  1  vector mask bit
- intr_req  in  NUM_VEC  one-cycle interrupt request per vector
- wr_valid  out  1  DW write request to host
- wr_ready  in  1  host accepts write
- wr_addr  out  64  write address
- wr_data  out  32  write data
- pba  out  NUM_VEC  pending bit array, registered
- sent_pulse  out  1  one-cycle pulse on write acceptance
- sent_idx  out  IDX_W  vector of the accepted write, valid with sent_pulse
- err_pulse  out  1  one-cycle pulse when a vector is dropped for a bad address

## Operation
- Table reset state: addr=0, data=0, mask=1 for every entry; pba=0; rr pointer=0.
- intr_req[i]=1 sets pba[i]. A request on an already-pending vector coalesces; no second message is generated.
- Eligible vector: pba[i] & ~mask[i], gated by msix_en & ~func_mask. Masked vectors stay pending and issue after unmask.
- FSM IDLE: if any vector is eligible, grant the vector selected round-robin.
  - Search starts at rr_ptr; rr_ptr becomes grant+1 (mod NUM_VEC).
  - Capture table addr/data into the output regs and clear pba[grant].
  - If the captured addr is 0 or addr[1:0]!=0: pulse err_pulse, stay IDLE, no write is issued.
  - Otherwise go to ISSUE.
- FSM ISSUE: wr_valid=1 and wr_addr/wr_data are held stable until wr_ready.
  - On wr_valid&wr_ready: sent_pulse=1, sent_idx=grant, return to IDLE.
  - wr_valid is never withdrawn once asserted, even if msix_en or func_mask drops, or the entry is masked or rewritten.
- Table writes take effect the next cycle. A write to the in-flight entry does not alter the held wr_addr/wr_data.
- intr_req[i] arriving while vector i is in ISSUE sets pba[i] again, giving a second message later.
- intr_req[i] in the same cycle as the grant clear of i: set wins (pba[i]=1 next cycle).
- Index tbl_wr_idx >= NUM_VEC: the write is ignored.

## Timing
- Reset (rst_n=0 at edge): FSM=IDLE, wr_valid=0, wr_addr=0, wr_data=0, pba=0, sent_pulse=0, sent_idx=0, err_pulse=0, table to reset state. Reset mid-ISSUE drops the in-flight write.
- intr_req at edge N: pba visible at N+1.
- Grant evaluated in IDLE at N+1, so wr_valid rises at N+2. Minimum request-to-valid latency is 2 cycles.
- With wr_ready held high, the write is accepted at the first wr_valid cycle, and IDLE follows.
- Throughput: one message per 2 cycles max (IDLE/ISSUE alternate).
- sent_pulse is registered: it asserts in the cycle after the handshake edge for exactly 1 cycle.
- err_pulse asserts in the cycle after the grant edge for exactly 1 cycle.
- Unmask (tbl_wr_mask=0) at edge M for a pending vector: eligible at M+1, wr_valid at M+2.

## Test plan
- Single vector: program idx2 addr=0xFEE0_0040 data=0x0000_0022 mask=0, msix_en=1, pulse intr_req[2], wr_ready=1.
  - Expect wr_valid 2 cycles later with that addr/data, sent_idx=2, pba[2] back to 0.
- Round robin: vectors 0,1,3 all pending in the same cycle.
  - Expect writes in order 0,1,3, each at 2-cycle spacing.
  - Then re-pend 0 and 3: expect order 0,3 (pointer=4 after 3, wraps to 0).
- Mask/backpressure: vector 5 masked, intr_req[5] -> pba[5]=1 and no write.
  - Unmask with wr_ready=0 for 10 cycles: wr_valid held with addr/data stable.
  - Rewrite entry 5 data to 0xDEAD during the hold: the held data stays the old value.
  - Release ready -> one write.
- Coalesce/re-arm: intr_req[1] on 3 consecutive cycles before grant -> exactly one message.
  - intr_req[1] during ISSUE -> a second message after the first.
- Bad address: idx4 addr=0x1002 -> err_pulse=1, no wr_valid, pba[4]=0.
  - Also func_mask=1 blocks all writes, with pending bits kept.
- Reset mid-ISSUE: rst_n=0 with wr_valid=1 -> next cycle all outputs 0, pba=0, all masks=1.

Source files
------------

// File: rtl/msix_vec_gen.sv
// msix_vec_gen: MSI-X message generator.
// Holds a per-vector table (address, data, mask) and a pending-bit array.
// Pending, unmasked vectors are granted round-robin. Each grant produces one
// DW memory write toward the host.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   msix_en           MSI-X enable
//   func_mask         function mask, blocks all issuance while high
//   tbl_wr_*          table entry write (index, address, data, mask)
//   intr_req          per-vector one-cycle interrupt request
//   wr_valid/ready    DW write handshake; wr_addr/wr_data is the payload
//   pba               pending bit array
//   sent_pulse/idx    one-cycle report of an accepted write
//   err_pulse         one-cycle report of a vector dropped for a bad address
module msix_vec_gen #(
    parameter int unsigned NUM_VEC = 8,
    parameter int unsigned IDX_W   = $clog2(NUM_VEC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               msix_en,
    input  logic               func_mask,
    input  logic               tbl_wr_en,
    input  logic [IDX_W-1:0]   tbl_wr_idx,
    input  logic [63:0]        tbl_wr_addr,
    input  logic [31:0]        tbl_wr_data,
    input  logic               tbl_wr_mask,
    input  logic [NUM_VEC-1:0] intr_req,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [63:0]        wr_addr,
    output logic [31:0]        wr_data,
    output logic [NUM_VEC-1:0] pba,
    output logic               sent_pulse,
    output logic [IDX_W-1:0]   sent_idx,
    output logic               err_pulse
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t             state;
    logic [63:0]        tbl_addr [NUM_VEC];
    logic [31:0]        tbl_data [NUM_VEC];
    logic [NUM_VEC-1:0] tbl_mask;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   cur_idx;

    logic [NUM_VEC-1:0] elig_c;
    logic               grant_vld_c;
    logic [IDX_W-1:0]   grant_idx_c;
    logic [IDX_W-1:0]   rr_next_c;
    logic               grant_bad_c;
    logic [NUM_VEC-1:0] grant_clr_c;
    logic               idx_ok_c;

    // Vectors that may issue right now.
    assign elig_c = (msix_en && !func_mask) ? (pba & ~tbl_mask) : '0;

    // Round-robin search starting at rr_ptr; first eligible vector wins.
    always_comb begin
        int unsigned j;
        j           = 0;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        for (int unsigned k = 0; k < NUM_VEC; k++) begin
            j = 32'(rr_ptr) + k;
            if (j >= NUM_VEC) begin
                j = j - NUM_VEC;
            end
            if (!grant_vld_c && elig_c[IDX_W'(j)]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = IDX_W'(j);
            end
        end
    end

    // Pointer moves just past the granted vector, wrapping at NUM_VEC.
    assign rr_next_c = (32'(grant_idx_c) + 32'd1 >= NUM_VEC) ? '0
                                                             : grant_idx_c + IDX_W'(1);

    // A zero or non-DW-aligned address cannot be issued.
    assign grant_bad_c = (tbl_addr[grant_idx_c] == 64'd0) ||
                         (tbl_addr[grant_idx_c][1:0] != 2'b00);

    assign idx_ok_c = (32'(tbl_wr_idx) < NUM_VEC);

    // Pending bit cleared by this cycle's grant.
    always_comb begin
        grant_clr_c = '0;
        if (state == S_IDLE && grant_vld_c) begin
            grant_clr_c[grant_idx_c] = 1'b1;
        end
    end

    // MSI-X table storage; a write is visible from the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_mask <= '1;
            for (int i = 0; i < NUM_VEC; i++) begin
                tbl_addr[i] <= 64'd0;
                tbl_data[i] <= 32'd0;
            end
        end else if (tbl_wr_en && idx_ok_c) begin
            tbl_addr[tbl_wr_idx] <= tbl_wr_addr;
            tbl_data[tbl_wr_idx] <= tbl_wr_data;
            tbl_mask[tbl_wr_idx] <= tbl_wr_mask;
        end
    end

    // Pending bits, grant FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_valid   <= 1'b0;
            wr_addr    <= 64'd0;
            wr_data    <= 32'd0;
            pba        <= '0;
            sent_pulse <= 1'b0;
            sent_idx   <= '0;
            err_pulse  <= 1'b0;
            rr_ptr     <= '0;
            cur_idx    <= '0;
        end else begin
            sent_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            // A new request beats the grant clear of the same vector.
            pba        <= (pba & ~grant_clr_c) | intr_req;
            case (state)
                S_IDLE: begin
                    if (grant_vld_c) begin
                        rr_ptr  <= rr_next_c;
                        cur_idx <= grant_idx_c;
                        wr_addr <= tbl_addr[grant_idx_c];
                        wr_data <= tbl_data[grant_idx_c];
                        if (grant_bad_c) begin
                            err_pulse <= 1'b1;
                        end else begin
                            wr_valid <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Payload is held until accepted regardless of enables or table updates.
                    if (wr_ready) begin
                        wr_valid   <= 1'b0;
                        sent_pulse <= 1'b1;
                        sent_idx   <= cur_idx;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msix_vec_gen.sv
// Testbench for msix_vec_gen: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural reference model.
module tb_msix_vec_gen;

    localparam int NUM_VEC = 8;
    localparam int IDX_W   = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               msix_en;
    logic               func_mask;
    logic               tbl_wr_en;
    logic [IDX_W-1:0]   tbl_wr_idx;
    logic [63:0]        tbl_wr_addr;
    logic [31:0]        tbl_wr_data;
    logic               tbl_wr_mask;
    logic [NUM_VEC-1:0] intr_req;
    logic               wr_valid;
    logic               wr_ready;
    logic [63:0]        wr_addr;
    logic [31:0]        wr_data;
    logic [NUM_VEC-1:0] pba;
    logic               sent_pulse;
    logic [IDX_W-1:0]   sent_idx;
    logic               err_pulse;

    msix_vec_gen #(.NUM_VEC(NUM_VEC), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .msix_en    (msix_en),
        .func_mask  (func_mask),
        .tbl_wr_en  (tbl_wr_en),
        .tbl_wr_idx (tbl_wr_idx),
        .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data),
        .tbl_wr_mask(tbl_wr_mask),
        .intr_req   (intr_req),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pba        (pba),
        .sent_pulse (sent_pulse),
        .sent_idx   (sent_idx),
        .err_pulse  (err_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    logic [63:0]        m_addr [NUM_VEC];
    logic [31:0]        m_data [NUM_VEC];
    bit                 m_mask [NUM_VEC];
    logic [NUM_VEC-1:0] m_pba;
    int                 m_ptr;
    bit                 m_busy;
    int                 m_cur;
    logic [63:0]        m_hold_addr;
    logic [31:0]        m_hold_data;
    bit                 exp_sent;
    int                 exp_sidx;
    bit                 exp_err;

    // Observed accepted writes (vector, cycle)
    int sent_q[$];
    int sent_cyc_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model of one clock edge, using the inputs presented at that edge.
    task automatic model_step();
        logic [NUM_VEC-1:0] npba;
        bit found;
        int g;
        exp_sent = 1'b0;
        exp_err  = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_pba = '0; m_ptr = 0; m_cur = 0;
            m_hold_addr = '0; m_hold_data = '0;
            for (int i = 0; i < NUM_VEC; i++) begin
                m_addr[i] = '0; m_data[i] = '0; m_mask[i] = 1'b1;
            end
            return;
        end
        npba = m_pba;
        if (m_busy) begin
            if (wr_ready) begin
                exp_sent = 1'b1; exp_sidx = m_cur; m_busy = 1'b0;
            end
        end else if (msix_en && !func_mask) begin
            found = 1'b0; g = 0;
            for (int k = 0; k < NUM_VEC; k++) begin
                int v;
                v = (m_ptr + k) % NUM_VEC;
                if (!found && m_pba[v] && !m_mask[v]) begin
                    found = 1'b1; g = v;
                end
            end
            if (found) begin
                npba[g]     = 1'b0;
                m_ptr       = (g + 1) % NUM_VEC;
                m_hold_addr = m_addr[g];
                m_hold_data = m_data[g];
                if (m_addr[g] == 64'd0 || (m_addr[g] % 4) != 0) exp_err = 1'b1;
                else begin
                    m_busy = 1'b1; m_cur = g;
                end
            end
        end
        m_pba = npba | intr_req;
        if (tbl_wr_en && int'(tbl_wr_idx) < NUM_VEC) begin
            m_addr[tbl_wr_idx] = tbl_wr_addr;
            m_data[tbl_wr_idx] = tbl_wr_data;
            m_mask[tbl_wr_idx] = tbl_wr_mask;
        end
    endtask

    // Advance one cycle, update the model, compare #1 after the edge,
    // then drop one-cycle strobes.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("wr_valid", 64'(wr_valid), 64'(m_busy));
        if (m_busy) begin
            chk("wr_addr", wr_addr, m_hold_addr);
            chk("wr_data", 64'(wr_data), 64'(m_hold_data));
        end
        chk("pba", 64'(pba), 64'(m_pba));
        chk("sent_pulse", 64'(sent_pulse), 64'(exp_sent));
        if (exp_sent) chk("sent_idx", 64'(sent_idx), 64'(exp_sidx));
        chk("err_pulse", 64'(err_pulse), 64'(exp_err));
        if (sent_pulse) begin
            sent_q.push_back(int'(sent_idx));
            sent_cyc_q.push_back(cyc);
        end
        intr_req  = '0;
        tbl_wr_en = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic prog(input int idx, input logic [63:0] a, input logic [31:0] d, input bit m);
        tbl_wr_en   = 1'b1;
        tbl_wr_idx  = IDX_W'(idx);
        tbl_wr_addr = a;
        tbl_wr_data = d;
        tbl_wr_mask = m;
        step();
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 5))
            0:       a = 64'd0;
            1:       a = 64'h1002;
            2:       a = {$urandom(), $urandom()} | 64'h1;
            default: a = {$urandom(), $urandom() & 32'hFFFF_FFFC} | 64'h4;
        endcase
        return a;
    endfunction

    initial begin
        rst_n = 1'b0; msix_en = 1'b0; func_mask = 1'b0; tbl_wr_en = 1'b0;
        tbl_wr_idx = '0; tbl_wr_addr = '0; tbl_wr_data = '0; tbl_wr_mask = 1'b0;
        intr_req = '0; wr_ready = 1'b0;
        for (int i = 0; i < NUM_VEC; i++) begin
            m_addr[i] = '0; m_data[i] = '0; m_mask[i] = 1'b1;
        end
        m_pba = '0; m_ptr = 0; m_busy = 1'b0; m_cur = 0;
        m_hold_addr = '0; m_hold_data = '0; exp_sidx = 0;

        // Reset state
        steps(2);
        chk("rst_wr_addr", wr_addr, 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_sent_idx", 64'(sent_idx), 64'd0);
        rst_n = 1'b1;
        step();

        // Round robin: 0,1,3 pending together, then 0 and 3 again
        msix_en = 1'b1; wr_ready = 1'b1;
        prog(0, 64'hFEE0_0000, 32'h10, 1'b0);
        prog(1, 64'hFEE0_0010, 32'h11, 1'b0);
        prog(3, 64'hFEE0_0030, 32'h13, 1'b0);
        sent_q.delete(); sent_cyc_q.delete();
        intr_req = 8'b0000_1011;
        steps(9);
        chk("rr_count", 64'(sent_q.size()), 64'd3);
        if (sent_q.size() == 3) begin
            chk("rr_first", 64'(sent_q[0]), 64'd0);
            chk("rr_second", 64'(sent_q[1]), 64'd1);
            chk("rr_third", 64'(sent_q[2]), 64'd3);
            chk("rr_spacing1", 64'(sent_cyc_q[1] - sent_cyc_q[0]), 64'd2);
            chk("rr_spacing2", 64'(sent_cyc_q[2] - sent_cyc_q[1]), 64'd2);
        end
        sent_q.delete();
        intr_req = 8'b0000_1001;
        steps(7);
        chk("rr_wrap_count", 64'(sent_q.size()), 64'd2);
        if (sent_q.size() == 2) begin
            chk("rr_wrap_first", 64'(sent_q[0]), 64'd0);
            chk("rr_wrap_second", 64'(sent_q[1]), 64'd3);
        end

        // Single vector, 2-cycle request-to-valid latency
        prog(2, 64'hFEE0_0040, 32'h0000_0022, 1'b0);
        intr_req = 8'b0000_0100;
        step();
        step();
        chk("sv_valid", 64'(wr_valid), 64'd1);
        chk("sv_addr", wr_addr, 64'hFEE0_0040);
        chk("sv_data", 64'(wr_data), 64'h22);
        step();
        chk("sv_sent", 64'(sent_pulse), 64'd1);
        chk("sv_idx", 64'(sent_idx), 64'd2);
        chk("sv_pba2", 64'(pba[2]), 64'd0);
        steps(2);

        // Mask / backpressure / rewrite of the in-flight entry
        prog(5, 64'hFEE0_1050, 32'h55, 1'b1);
        intr_req = 8'b0010_0000;
        steps(3);
        chk("mask_pending", 64'(pba[5]), 64'd1);
        chk("mask_no_valid", 64'(wr_valid), 64'd0);
        wr_ready = 1'b0;
        prog(5, 64'hFEE0_1050, 32'h55, 1'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                tbl_wr_en = 1'b1; tbl_wr_idx = 3'd5; tbl_wr_addr = 64'hFEE0_1050;
                tbl_wr_data = 32'hDEAD; tbl_wr_mask = 1'b0;
            end
            step();
        end
        chk("hold_valid", 64'(wr_valid), 64'd1);
        chk("hold_data", 64'(wr_data), 64'h55);
        sent_q.delete();
        wr_ready = 1'b1;
        steps(3);
        chk("mask_sent_count", 64'(sent_q.size()), 64'd1);

        // Coalesce while blocked, then re-arm during ISSUE
        func_mask = 1'b1;
        for (int i = 0; i < 3; i++) begin
            intr_req = 8'b0000_0010;
            step();
        end
        sent_q.delete();
        func_mask = 1'b0;
        steps(6);
        chk("coalesce_count", 64'(sent_q.size()), 64'd1);
        wr_ready = 1'b0;
        intr_req = 8'b0000_0010;
        steps(2);
        intr_req = 8'b0000_0010;
        step();
        chk("rearm_pba", 64'(pba[1]), 64'd1);
        wr_ready = 1'b1;
        steps(6);
        chk("rearm_count", 64'(sent_q.size()), 64'd3);

        // Bad address drop, then function mask hold-off
        prog(4, 64'h1002, 32'h44, 1'b0);
        intr_req = 8'b0001_0000;
        step();
        step();
        chk("bad_err", 64'(err_pulse), 64'd1);
        chk("bad_no_valid", 64'(wr_valid), 64'd0);
        chk("bad_pba4", 64'(pba[4]), 64'd0);
        func_mask = 1'b1;
        intr_req = 8'b0000_1001;
        steps(4);
        chk("fmask_no_valid", 64'(wr_valid), 64'd0);
        chk("fmask_pending", 64'(pba & 8'b0000_1001), 64'h9);
        func_mask = 1'b0;
        steps(6);

        // Reset while a write is in flight
        wr_ready = 1'b0;
        intr_req = 8'b0000_0100;
        steps(2);
        chk("rst_mid_valid_before", 64'(wr_valid), 64'd1);
        rst_n = 1'b0;
        step();
        chk("rst_mid_addr", wr_addr, 64'd0);
        chk("rst_mid_data", 64'(wr_data), 64'd0);
        rst_n = 1'b1;
        wr_ready = 1'b1;
        intr_req = '1;
        steps(3);
        chk("rst_masks_block", 64'(wr_valid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 599) != 0);
            msix_en   = ($urandom_range(0, 19) != 0);
            func_mask = ($urandom_range(0, 14) == 0);
            wr_ready  = ($urandom_range(0, 9) < 6);
            intr_req  = ($urandom_range(0, 2) == 0) ? NUM_VEC'($urandom() & $urandom()) : '0;
            if ($urandom_range(0, 7) == 0) begin
                tbl_wr_en   = 1'b1;
                tbl_wr_idx  = IDX_W'($urandom_range(0, NUM_VEC - 1));
                tbl_wr_addr = rand_addr();
                tbl_wr_data = $urandom();
                tbl_wr_mask = ($urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
